// File: rtl/mem_wb.sv
// ---------------------------------------------------------------------------
// mem_wb -- memory / write-back stage.
//
// Takes the execute stage's result bundle and turns it into a data-memory
// request, a register-file write or a PC redirect. Non-memory ops commit one
// cycle after acceptance at full throughput. Loads and stores hold the stage
// in ACCESS (exe_ready low) until the memory acknowledges the request.
//
// Optional feature: define MEM_WB_TIMEOUT_EN to abort an ACCESS that sees no
// dmem_ack within MEM_TIMEOUT cycles; the abort sets the sticky mem_err flag.
// Without the macro the stage waits for the ack indefinitely and mem_err is 0.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   exe_valid/exe_ready   bundle handshake with the execute stage
//   exe_out               ALU result, or memory address for loads/stores
//   z_flag, is_branch     branch condition and branch marker
//   pc_target             branch target
//   needs_wb, wb_addr     register-file write request and destination
//   is_load, is_store     memory op markers (both set = store)
//   store_data            store write data
//   dmem_req/we/addr/wdata  data-memory request, held until dmem_ack
//   dmem_ack, dmem_rdata  memory completion and load data
//   rf_we/waddr/wdata     register-file write port (rf_we is a pulse)
//   br_taken, br_target   PC redirect (br_taken is a pulse)
//   mem_err               sticky memory-timeout flag
// ---------------------------------------------------------------------------
module mem_wb #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 4
`ifdef MEM_WB_TIMEOUT_EN
    ,
    parameter int MEM_TIMEOUT = 15
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              exe_valid,
    output logic              exe_ready,
    input  logic [DATA_W-1:0] exe_out,
    input  logic              z_flag,
    input  logic              is_branch,
    input  logic [DATA_W-1:0] pc_target,
    input  logic              needs_wb,
    input  logic              is_load,
    input  logic              is_store,
    input  logic [DATA_W-1:0] store_data,
    input  logic [REG_AW-1:0] wb_addr,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              br_taken,
    output logic [DATA_W-1:0] br_target,
    output logic              mem_err
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    state_t              state_q,      state_d;
    logic                dmem_req_q,   dmem_req_d;
    logic                dmem_we_q,    dmem_we_d;
    logic [DATA_W-1:0]   dmem_addr_q,  dmem_addr_d;
    logic [DATA_W-1:0]   dmem_wdata_q, dmem_wdata_d;
    logic                rf_we_q,      rf_we_d;
    logic [REG_AW-1:0]   rf_waddr_q,   rf_waddr_d;
    logic [DATA_W-1:0]   rf_wdata_q,   rf_wdata_d;
    logic                br_taken_q,   br_taken_d;
    logic [DATA_W-1:0]   br_target_q,  br_target_d;
    // Destination of the in-flight load, captured at acceptance.
    logic [REG_AW-1:0]   lat_waddr_q,  lat_waddr_d;
    logic                lat_wb_q,     lat_wb_d;
    logic                is_mem_s;

`ifdef MEM_WB_TIMEOUT_EN
    localparam int TMO_W = $clog2(MEM_TIMEOUT + 1);
    // Count value seen in the last ACCESS cycle before the abort fires.
    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(MEM_TIMEOUT - 1);
    localparam logic [TMO_W-1:0] TMO_ONE   = TMO_W'(1);

    logic [TMO_W-1:0]    tmo_cnt_q,    tmo_cnt_d;
    logic                mem_err_q,    mem_err_d;
`endif

    assign exe_ready  = (state_q == ST_IDLE);
    assign is_mem_s   = is_load | is_store;

    assign dmem_req   = dmem_req_q;
    assign dmem_we    = dmem_we_q;
    assign dmem_addr  = dmem_addr_q;
    assign dmem_wdata = dmem_wdata_q;
    assign rf_we      = rf_we_q;
    assign rf_waddr   = rf_waddr_q;
    assign rf_wdata   = rf_wdata_q;
    assign br_taken   = br_taken_q;
    assign br_target  = br_target_q;
`ifdef MEM_WB_TIMEOUT_EN
    assign mem_err    = mem_err_q;
`else
    assign mem_err    = 1'b0;
`endif

    // Next-state and next-output computation for the IDLE/ACCESS controller.
    always_comb begin
        state_d      = state_q;
        dmem_req_d   = dmem_req_q;
        dmem_we_d    = dmem_we_q;
        dmem_addr_d  = dmem_addr_q;
        dmem_wdata_d = dmem_wdata_q;
        rf_we_d      = 1'b0;
        rf_waddr_d   = rf_waddr_q;
        rf_wdata_d   = rf_wdata_q;
        br_taken_d   = 1'b0;
        br_target_d  = br_target_q;
        lat_waddr_d  = lat_waddr_q;
        lat_wb_d     = lat_wb_q;
`ifdef MEM_WB_TIMEOUT_EN
        tmo_cnt_d    = tmo_cnt_q;
        mem_err_d    = mem_err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (exe_valid) begin
                    if (is_mem_s) begin
                        // is_store wins when both markers are set; branch is ignored.
                        state_d      = ST_ACCESS;
                        dmem_req_d   = 1'b1;
                        dmem_we_d    = is_store;
                        dmem_addr_d  = exe_out;
                        dmem_wdata_d = store_data;
                        lat_waddr_d  = wb_addr;
                        lat_wb_d     = needs_wb;
`ifdef MEM_WB_TIMEOUT_EN
                        tmo_cnt_d    = {TMO_W{1'b0}};
`endif
                    end else begin
                        rf_we_d      = needs_wb;
                        rf_waddr_d   = wb_addr;
                        rf_wdata_d   = exe_out;
                        br_taken_d   = is_branch & z_flag;
                        br_target_d  = pc_target;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (dmem_ack) begin
                    // An ack in the limit cycle completes normally.
                    state_d    = ST_IDLE;
                    dmem_req_d = 1'b0;
                    if (!dmem_we_q && lat_wb_q) begin
                        rf_we_d    = 1'b1;
                        rf_waddr_d = lat_waddr_q;
                        rf_wdata_d = dmem_rdata;
                    end else begin
                        rf_we_d    = 1'b0;
                    end
                end
`ifdef MEM_WB_TIMEOUT_EN
                else if (tmo_cnt_q == TMO_LIMIT) begin
                    state_d    = ST_IDLE;
                    dmem_req_d = 1'b0;
                    mem_err_d  = 1'b1;
                end else begin
                    tmo_cnt_d  = tmo_cnt_q + TMO_ONE;
                end
`else
                else begin
                    state_d = ST_ACCESS;
                end
`endif
            end
            default: begin
                state_d    = ST_IDLE;
                dmem_req_d = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset drops any in-flight transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= {DATA_W{1'b0}};
            dmem_wdata_q <= {DATA_W{1'b0}};
            rf_we_q      <= 1'b0;
            rf_waddr_q   <= {REG_AW{1'b0}};
            rf_wdata_q   <= {DATA_W{1'b0}};
            br_taken_q   <= 1'b0;
            br_target_q  <= {DATA_W{1'b0}};
            lat_waddr_q  <= {REG_AW{1'b0}};
            lat_wb_q     <= 1'b0;
`ifdef MEM_WB_TIMEOUT_EN
            tmo_cnt_q    <= {TMO_W{1'b0}};
            mem_err_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            dmem_req_q   <= dmem_req_d;
            dmem_we_q    <= dmem_we_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_wdata_q <= dmem_wdata_d;
            rf_we_q      <= rf_we_d;
            rf_waddr_q   <= rf_waddr_d;
            rf_wdata_q   <= rf_wdata_d;
            br_taken_q   <= br_taken_d;
            br_target_q  <= br_target_d;
            lat_waddr_q  <= lat_waddr_d;
            lat_wb_q     <= lat_wb_d;
`ifdef MEM_WB_TIMEOUT_EN
            tmo_cnt_q    <= tmo_cnt_d;
            mem_err_q    <= mem_err_d;
`endif
        end
    end

endmodule

// File: tb/tb_mem_wb.sv
// ---------------------------------------------------------------------------
// tb_mem_wb -- scoreboard bench for mem_wb.
// The driver pushes expected RF writes, redirects and memory requests (with
// the cycle they must appear in) into queues; a negedge monitor pops and
// compares whenever the DUT raises rf_we, br_taken or a new dmem_req.
// ---------------------------------------------------------------------------
module tb_mem_wb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        exe_valid;
    logic        exe_ready;
    logic [31:0] exe_out;
    logic        z_flag;
    logic        is_branch;
    logic [31:0] pc_target;
    logic        needs_wb;
    logic        is_load;
    logic        is_store;
    logic [31:0] store_data;
    logic [3:0]  wb_addr;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        br_taken;
    logic [31:0] br_target;
    logic        mem_err;

    mem_wb dut (
        .clk(clk), .rst_n(rst_n), .exe_valid(exe_valid), .exe_ready(exe_ready),
        .exe_out(exe_out), .z_flag(z_flag), .is_branch(is_branch),
        .pc_target(pc_target), .needs_wb(needs_wb), .is_load(is_load),
        .is_store(is_store), .store_data(store_data), .wb_addr(wb_addr),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .br_taken(br_taken), .br_target(br_target), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    typedef struct {
        int          cyc;
        logic [31:0] addr;
        logic [31:0] data;
        logic        we;
        int          hold;   // expected dmem_req high cycles, 0 = not checked
    } exp_t;

    exp_t rf_q[$];
    exp_t br_q[$];
    exp_t mem_q[$];

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag_unexpected(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: got an output event, expected none (cycle %0d)", name, cyc);
    endtask

    // Monitor: compares every DUT output event against the scoreboard.
    exp_t cur_mem;
    logic req_prev   = 1'b0;
    logic stable_bad = 1'b0;
    int   held       = 0;

    always @(negedge clk) begin
        exp_t e;
        if (rf_we) begin
            if (rf_q.size() == 0) flag_unexpected("rf_unexpected");
            else begin
                e = rf_q.pop_front();
                check("rf_cycle", 64'(cyc), 64'(e.cyc));
                check("rf_waddr", 64'(rf_waddr), 64'(e.addr[3:0]));
                check("rf_wdata", 64'(rf_wdata), 64'(e.data));
            end
        end
        if (br_taken) begin
            if (br_q.size() == 0) flag_unexpected("br_unexpected");
            else begin
                e = br_q.pop_front();
                check("br_cycle", 64'(cyc), 64'(e.cyc));
                check("br_target", 64'(br_target), 64'(e.addr));
            end
        end
        if (dmem_req && !req_prev) begin
            if (mem_q.size() == 0) flag_unexpected("mem_unexpected");
            else begin
                cur_mem = mem_q.pop_front();
                check("mem_cycle", 64'(cyc), 64'(cur_mem.cyc));
                check("mem_addr", 64'(dmem_addr), 64'(cur_mem.addr));
                check("mem_we", 64'(dmem_we), 64'(cur_mem.we));
                check("mem_wdata", 64'(dmem_wdata), 64'(cur_mem.data));
            end
            held = 1;
            stable_bad = 1'b0;
        end else if (dmem_req && req_prev) begin
            held++;
            if (dmem_addr !== cur_mem.addr || dmem_we !== cur_mem.we || dmem_wdata !== cur_mem.data)
                stable_bad = 1'b1;
        end else if (!dmem_req && req_prev) begin
            check("mem_stable", 64'(stable_bad), 64'd0);
            if (cur_mem.hold != 0) check("mem_hold", 64'(held), 64'(cur_mem.hold));
        end
        req_prev = dmem_req;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        exe_valid = 1'b0; exe_out = 32'h0; z_flag = 1'b0; is_branch = 1'b0;
        pc_target = 32'h0; needs_wb = 1'b0; is_load = 1'b0; is_store = 1'b0;
        store_data = 32'h0; wb_addr = 4'h0;
    endtask

    task automatic issue(input logic ld, input logic st, input logic br, input logic z,
                         input logic nwb, input logic [3:0] wa, input logic [31:0] eo,
                         input logic [31:0] sd, input logic [31:0] pt);
        exe_valid = 1'b1; is_load = ld; is_store = st; is_branch = br; z_flag = z;
        needs_wb = nwb; wb_addr = wa; exe_out = eo; store_data = sd; pc_target = pt;
    endtask

    task automatic push_rf(input int c, input logic [3:0] a, input logic [31:0] d);
        exp_t e;
        e.cyc = c; e.addr = {28'h0, a}; e.data = d; e.we = 1'b1; e.hold = 0;
        rf_q.push_back(e);
    endtask

    task automatic push_br(input int c, input logic [31:0] t);
        exp_t e;
        e.cyc = c; e.addr = t; e.data = 32'h0; e.we = 1'b0; e.hold = 0;
        br_q.push_back(e);
    endtask

    task automatic push_mem(input int c, input logic [31:0] a, input logic [31:0] d,
                            input logic w, input int h);
        exp_t e;
        e.cyc = c; e.addr = a; e.data = d; e.we = w; e.hold = h;
        mem_q.push_back(e);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_ctl"}, {59'h0, rf_we, br_taken, dmem_req, dmem_we, mem_err}, 64'h0);
        check({name, "_mem"}, {dmem_addr, dmem_wdata}, 64'h0);
        check({name, "_rf"},  {28'h0, rf_waddr, rf_wdata}, 64'h0);
        check({name, "_br"},  64'(br_target), 64'h0);
    endtask

    logic [3:0]  alu_wa[3] = '{4'd1, 4'd2, 4'd3};
    logic [31:0] alu_eo[3] = '{32'h10, 32'h20, 32'h30};

    initial begin
        rst_n = 1'b0;
        dmem_ack = 1'b0;
        dmem_rdata = 32'h0;
        clear_in();
        repeat (2) tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();
        check("ready_after_reset", 64'(exe_ready), 64'd1);

        // ALU stream: three back-to-back commits.
        for (int i = 0; i < 3; i++) begin
            issue(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, alu_wa[i], alu_eo[i], 32'h0, 32'h0);
            push_rf(cyc + 1, alu_wa[i], alu_eo[i]);
            check("alu_ready", 64'(exe_ready), 64'd1);
            tick();
        end
        clear_in();
        tick();

        // Taken branch, then not-taken branch.
        issue(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 32'h40);
        push_br(cyc + 1, 32'h40);
        tick();
        clear_in();
        tick();
        issue(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h80);
        tick();
        clear_in();
        check("br_target_nt", 64'(br_target), 64'h80);
        tick();

        // Load acknowledged in its third request cycle.
        issue(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd5, 32'h100, 32'h0, 32'h0);
        push_mem(cyc + 1, 32'h100, 32'h0, 1'b0, 3);
        tick();
        clear_in();
        check("load_ready1", 64'(exe_ready), 64'd0);
        tick();
        check("load_ready2", 64'(exe_ready), 64'd0);
        tick();
        dmem_ack = 1'b1;
        dmem_rdata = 32'hDEADBEEF;
        push_rf(cyc + 1, 4'd5, 32'hDEADBEEF);
        check("load_ready3", 64'(exe_ready), 64'd0);
        tick();
        dmem_ack = 1'b0;
        check("load_ready_after_ack", 64'(exe_ready), 64'd1);
        check("load_req_dropped", 64'(dmem_req), 64'd0);

        // Store acked at once; a bundle offered during ACCESS must not be taken.
        issue(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd7, 32'h200, 32'h1234, 32'h0);
        push_mem(cyc + 1, 32'h200, 32'h1234, 1'b1, 1);
        tick();
        issue(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd9, 32'h999, 32'h0, 32'h0);
        dmem_ack = 1'b1;
        check("store_ready", 64'(exe_ready), 64'd0);
        tick();
        dmem_ack = 1'b0;
        clear_in();
        check("store_ready_after_ack", 64'(exe_ready), 64'd1);
        check("store_req_dropped", 64'(dmem_req), 64'd0);
        tick();

        // Load+store markers with a taken branch: a store, no redirect, no RF write.
        issue(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'd8, 32'h300, 32'h55, 32'h44);
        push_mem(cyc + 1, 32'h300, 32'h55, 1'b1, 1);
        tick();
        clear_in();
        dmem_ack = 1'b1;
        tick();
        dmem_ack = 1'b0;
        tick();

        // Minimum-latency load.
        issue(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd6, 32'h104, 32'h0, 32'h0);
        push_mem(cyc + 1, 32'h104, 32'h0, 1'b0, 1);
        tick();
        clear_in();
        dmem_ack = 1'b1;
        dmem_rdata = 32'hCAFEF00D;
        push_rf(cyc + 1, 4'd6, 32'hCAFEF00D);
        tick();
        dmem_ack = 1'b0;
        tick();

        // Load without needs_wb: no RF write.
        issue(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2, 32'h108, 32'h0, 32'h0);
        push_mem(cyc + 1, 32'h108, 32'h0, 1'b0, 1);
        tick();
        clear_in();
        dmem_ack = 1'b1;
        dmem_rdata = 32'h0BADF00D;
        tick();
        dmem_ack = 1'b0;
        tick();

        // Asynchronous reset in the middle of an ACCESS.
        issue(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd4, 32'h400, 32'h0, 32'h0);
        push_mem(cyc + 1, 32'h400, 32'h0, 1'b0, 0);
        tick();
        clear_in();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("async_req_drop", 64'(dmem_req), 64'd0);
        check_all_zero("async_reset");
        tick();
        rst_n = 1'b1;
        dmem_ack = 1'b1;
        dmem_rdata = 32'h00000BAD;
        tick();
        dmem_ack = 1'b0;
        check("late_ack_req", 64'(dmem_req), 64'd0);
        check("late_ack_ready", 64'(exe_ready), 64'd1);
        tick();

`ifdef MEM_WB_TIMEOUT_EN
        // Ack in the 15th ACCESS cycle completes normally.
        issue(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 32'h500, 32'h0, 32'h0);
        push_mem(cyc + 1, 32'h500, 32'h0, 1'b0, 15);
        tick();
        clear_in();
        repeat (14) tick();
        dmem_ack = 1'b1;
        dmem_rdata = 32'h15;
        push_rf(cyc + 1, 4'd3, 32'h15);
        tick();
        dmem_ack = 1'b0;
        check("tmo_edge_err", 64'(mem_err), 64'd0);
        tick();

        // No ack: abort after 15 ACCESS cycles, mem_err sticky.
        issue(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 32'h600, 32'h0, 32'h0);
        push_mem(cyc + 1, 32'h600, 32'h0, 1'b0, 15);
        tick();
        clear_in();
        repeat (15) tick();
        check("tmo_req_drop", 64'(dmem_req), 64'd0);
        check("tmo_err_set", 64'(mem_err), 64'd1);
        check("tmo_ready", 64'(exe_ready), 64'd1);
        issue(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd10, 32'h77, 32'h0, 32'h0);
        push_rf(cyc + 1, 4'd10, 32'h77);
        tick();
        clear_in();
        tick();
        check("tmo_err_sticky", 64'(mem_err), 64'd1);
`else
        check("mem_err_tied", 64'(mem_err), 64'd0);
`endif

        repeat (3) tick();
        check("rf_q_drained", 64'(rf_q.size()), 64'd0);
        check("br_q_drained", 64'(br_q.size()), 64'd0);
        check("mem_q_drained", 64'(mem_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
